// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Reusable pipeline stage register with a valid/ready handshake, a
//   synchronous flush and an optional two-entry skid buffer. The payload is
//   an opaque DATA_WIDTH bus that the parent packs with the stage fields.
//
// Parameters
//   DATA_WIDTH      payload width in bits
//   SKID            1: two entries (main + skid), in_ready taken from a flop
//                   0: single entry, in_ready combinational from out_ready
//   CLEAR_ON_FLUSH  1: flush zeroes out_data, 0: out_data holds on flush
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous flush, empties the stage, drops a same-cycle input
//   in_valid   upstream payload valid
//   in_ready   stage can accept a payload this cycle
//   in_data    upstream payload
//   out_valid  out_data holds a valid payload
//   out_ready  downstream accepts the payload
//   out_data   registered payload (main register)
//   occupancy  entries held: 0..2 (0..1 when SKID=0)
module pipe_stage_reg #(
  parameter int unsigned DATA_WIDTH     = 71,
  parameter bit          SKID           = 1'b1,
  parameter bit          CLEAR_ON_FLUSH = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] m_q;
  logic [DATA_WIDTH-1:0] s_q;
  logic                  in_fire;
  logic                  out_fire;
  logic                  load_m;
  logic                  load_s;
  logic                  m_from_s;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath-load decode
  always_comb begin
    state_nxt = state;
    load_m    = 1'b0;
    load_s    = 1'b0;
    m_from_s  = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = ONE;
            load_m    = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_m = 1'b1;
          end else if (in_fire) begin
            // Without a skid register in_ready already implies out_fire
            // here, so this arm is only reachable when SKID=1.
            if (SKID) begin
              state_nxt = TWO;
              load_s    = 1'b1;
            end else begin
              load_m = 1'b1;
            end
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_nxt = ONE;
            m_from_s  = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    out_valid = (state != EMPTY);
    occupancy = state;
  end

  // Main register: the word presented downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
    end else if (flush) begin
      if (CLEAR_ON_FLUSH) begin
        m_q <= '0;
      end
    end else if (load_m) begin
      m_q <= in_data;
    end else if (m_from_s) begin
      m_q <= s_q;
    end
  end

  // Skid register: holds the second word while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
    end else if (flush) begin
      s_q <= '0;
    end else if (load_s) begin
      s_q <= in_data;
    end
  end

  assign out_data = m_q;

  generate
    if (SKID) begin : g_skid_ready
      // Registered ready: tracks whether the next state leaves a free slot.
      logic rdy_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdy_q <= 1'b1;
        end else begin
          rdy_q <= (state_nxt != TWO);
        end
      end
      assign in_ready = rdy_q;
    end else begin : g_comb_ready
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
//   Drives one SKID=1 and one SKID=0 instance of pipe_stage_reg from the same
//   inputs. The driver pushes each accepted payload into a per-instance
//   expected queue (and empties it on flush); an independent monitor pops and
//   compares on every out_fire and checks occupancy/valid/ready against the
//   queue depth each cycle.
module tb_pipe_stage_reg;
  localparam int W = 71;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;

  logic         a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [W-1:0] a_out_data, b_out_data;
  logic [1:0]   a_occ, b_occ;

  int errors = 0;
  int checks = 0;
  int pops_a = 0;
  int pops_b = 0;
  bit mon_en = 1'b0;
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  pipe_stage_reg #(.DATA_WIDTH(W), .SKID(1'b1), .CLEAR_ON_FLUSH(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .occupancy(a_occ)
  );

  pipe_stage_reg #(.DATA_WIDTH(W), .SKID(1'b0), .CLEAR_ON_FLUSH(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .occupancy(b_occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs and outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk_i("a_occ", int'(a_occ), qa.size());
      chk_i("a_out_valid", int'(a_out_valid), int'(qa.size() != 0));
      chk_i("a_in_ready", int'(a_in_ready), int'(qa.size() < 2));
      chk_i("b_occ", int'(b_occ), qb.size());
      chk_i("b_out_valid", int'(b_out_valid), int'(qb.size() != 0));
      chk_i("b_in_ready", int'(b_in_ready), int'((qb.size() == 0) || out_ready));
      if (a_out_valid && out_ready) begin
        if (qa.size() == 0) begin
          chk_i("a_unexpected_out", 1, 0);
        end else begin
          chk("a_data", a_out_data, qa.pop_front());
          pops_a++;
        end
      end
      if (b_out_valid && out_ready) begin
        if (qb.size() == 0) begin
          chk_i("b_unexpected_out", 1, 0);
        end else begin
          chk("b_data", b_out_data, qb.pop_front());
          pops_b++;
        end
      end
    end
  end

  // One cycle of stimulus; the expected queues are updated after the monitor
  // has handled this cycle's out_fire.
  task automatic drive(input bit v, input logic [W-1:0] d, input bit ordy, input bit fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    #1;
    if (fl) begin
      qa.delete();
      qb.delete();
    end else begin
      if (v && a_in_ready) qa.push_back(d);
      if (v && b_in_ready) qb.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pa, pb;
    logic [W-1:0] rd;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_i("rst_a_valid", int'(a_out_valid), 0);
    chk("rst_a_data", a_out_data, '0);
    chk_i("rst_a_ready", int'(a_in_ready), 1);
    chk_i("rst_a_occ", int'(a_occ), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // T2 streaming 0x11..0x88
    pa = pops_a;
    pb = pops_b;
    for (int i = 1; i <= 8; i++) begin
      rd = W'(i * 'h11);
      drive(1'b1, rd, 1'b1, 1'b0);
      chk_i("t2_a_occ", int'(a_occ), 1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk_i("t2_a_count", pops_a - pa, 8);
    chk_i("t2_b_count", pops_b - pb, 8);

    // T3 back-pressure on the skid instance
    drive(1'b1, W'('h0A), 1'b0, 1'b0);
    chk_i("t3_occ_a1", int'(a_occ), 1);
    drive(1'b1, W'('h0B), 1'b0, 1'b0);
    chk_i("t3_occ_a2", int'(a_occ), 2);
    chk_i("t3_ready_after_b", int'(a_in_ready), 0);
    drive(1'b1, W'('h0C), 1'b0, 1'b0);
    chk_i("t3_occ_hold", int'(a_occ), 2);
    chk("t3_hold_data", a_out_data, W'('h0A));
    pa = pops_a;
    drive(1'b1, W'('h0C), 1'b1, 1'b0);
    chk_i("t3_occ_drain1", int'(a_occ), 1);
    drive(1'b1, W'('h0C), 1'b1, 1'b0);
    chk_i("t3_occ_drain2", int'(a_occ), 1);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk_i("t3_occ_drain3", int'(a_occ), 0);
    chk_i("t3_a_count", pops_a - pa, 3);

    // T4 flush from TWO with a same-cycle input
    drive(1'b1, W'('h21), 1'b0, 1'b0);
    drive(1'b1, W'('h22), 1'b0, 1'b0);
    chk_i("t4_pre_occ", int'(a_occ), 2);
    drive(1'b1, W'('h23), 1'b0, 1'b1);
    chk_i("t4_a_valid", int'(a_out_valid), 0);
    chk_i("t4_a_occ", int'(a_occ), 0);
    chk_i("t4_a_ready", int'(a_in_ready), 1);
    chk("t4_a_data", a_out_data, '0);
    chk("t4_b_data", b_out_data, '0);
    pa = pops_a;
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk_i("t4_nothing_out", pops_a - pa, 0);

    // T5 combinational ready on the SKID=0 instance
    drive(1'b1, W'('h55), 1'b0, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk_i("t5_ready_low", int'(b_in_ready), 0);
    out_ready = 1'b1;
    #1;
    chk_i("t5_ready_high", int'(b_in_ready), 1);
    pb = pops_b;
    drive(1'b1, W'('h66), 1'b1, 1'b0);
    drive(1'b1, W'('h77), 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk_i("t5_b_count", pops_b - pb, 3);

    // T1 asynchronous reset mid-transfer
    drive(1'b1, W'('h99), 1'b0, 1'b0);
    drive(1'b1, W'('h9A), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_i("t1_a_valid", int'(a_out_valid), 0);
    chk("t1_a_data", a_out_data, '0);
    chk_i("t1_a_ready", int'(a_in_ready), 1);
    chk_i("t1_a_occ", int'(a_occ), 0);
    chk_i("t1_b_valid", int'(b_out_valid), 0);
    chk("t1_b_data", b_out_data, '0);
    qa.delete();
    qb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // T6 random traffic against the queue model
    for (int i = 0; i < 10000; i++) begin
      rd = W'({$urandom(), $urandom(), $urandom()});
      drive(($urandom % 4) != 0, rd, ($urandom % 3) != 0, ($urandom % 50) == 0);
      if (a_occ > 2'd2) chk_i("t6_occ_bound", int'(a_occ), 2);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk_i("end_qa_empty", qa.size(), 0);
    chk_i("end_qb_empty", qb.size(), 0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
